alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU (A, B, op -> R, Z) among N_REQ requesters.
//  - Round-robin grant, one operation in flight at a time.
//  - Holds operands stable for the ALU's settle/multiply latency, then returns R/Z tagged with the requester id.
//  - Sits between issuing units and the single shared ALU instance.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8); ID_W = $clog2(N_REQ) (localparam)
//  W        32  operand/result width
//  MUL_LAT  3   cycles operands are held for MUL (>=1); all other ops hold 1 cycle
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   N_REQ      per-requester request valid
//  req_ready  out  N_REQ      per-requester accept (one-hot or zero)
//  req_op     in   3*N_REQ    packed opcodes, requester i at [3i+2:3i]
//  req_a      in   W*N_REQ    packed operand A
//  req_b      in   W*N_REQ    packed operand B
//  alu_op     out  3          to shared ALU
//  alu_a      out  W          to shared ALU
//  alu_b      out  W          to shared ALU
//  alu_r      in   W          from shared ALU
//  alu_z      in   1          from shared ALU (R==0)
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response accept
//  rsp_id     out  ID_W       requester that owns the response
//  rsp_r      out  W          captured result
//  rsp_z      out  1          captured zero flag
//  rsp_err    out  1          opcode was illegal (000 or 111)
// BEHAVIOUR
//  Opcodes: 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SUB, 110 SLT (unsigned A<B -> 1).
//  - Illegal ops (000, 111) are still issued; the ALU returns R=0, Z=1, and rsp_err=1.
//  Reset: state IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_id/r/z/err=0, alu_op/a/b=0.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//  - IDLE: grant the first valid requester scanning ptr, ptr+1, ... mod N_REQ.
//    - req_ready[g]=1 for that cycle only.
//    - Latch op/a/b/id; cnt = (op==100) ? MUL_LAT-1 : 0; go EXEC.
//    - No valid requester -> stay IDLE, req_ready=0.
//  - EXEC: alu_op/a/b driven from the latched registers only, stable the whole EXEC period.
//    - cnt!=0 -> decrement.
//    - cnt==0 -> capture alu_r/alu_z into rsp_r/rsp_z, set rsp_err; go RESP.
//  - RESP: rsp_valid=1; rsp_id/r/z/err held stable until rsp_ready=1.
//    - On handshake: ptr = (id+1) mod N_REQ; rsp_valid=0 next cycle; go IDLE.
//  Latency, accept at cycle T:
//  - Non-MUL -> rsp_valid at T+2.
//  - MUL -> rsp_valid at T+1+MUL_LAT.
//  - Next accept no earlier than the cycle after the response handshake.
//  Handshake rules:
//  - req_ready is 0 in EXEC/RESP.
//  - A requester may drop req_valid before acceptance; nothing is recorded.
//  - Payload is sampled only in the accept cycle.
//  - rsp_ready is ignored outside RESP.
//  Width: MUL result truncated to low W bits (ALU behaviour); no sign handling here.
//  Reset mid-operation: the in-flight op is discarded, no response is produced, and all outputs return to reset values next cycle.
//  Simultaneous requests: exactly one is granted per IDLE cycle; losers keep req_ready=0.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined:
//  - Adds output stat_busy [31:0], counting cycles with state != IDLE.
//  - Saturates at 32'hFFFF_FFFF; cleared by rst.
//  ALU_ARB_STATS_EN undefined: port and counter are absent; the rest of the behaviour is identical.
// TESTING
//  1. req0 ADD A=5 B=7, rsp_ready=1 -> rsp_valid at T+2, rsp_id=0, rsp_r=12, rsp_z=0, rsp_err=0.
//  2. req2 MUL A=6 B=7, MUL_LAT=3 -> alu_a/b stable 3 cycles; rsp at T+4, rsp_r=42, rsp_id=2.
//  3. All req_valid=1 held, ADD ops, rsp_ready=1 -> grant order 0,1,2,3,0; one grant every 3 cycles.
//  4. rsp_ready=0 for 5 cycles in RESP -> rsp_* unchanged, req_ready=0; raise rsp_ready -> next grant follows.
//  5. SUB 3-3 -> r=0, z=1; SLT 2,9 -> r=1; op 111 -> r=0, z=1, rsp_err=1.
//  6. rst asserted during MUL EXEC -> next cycle rsp_valid=0, req_ready=0, ptr=0; no response issued.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bundle shared by the requesters, the arbiter and the single ALU.
// slave: arbiter side; master: requesters, response sink and ALU side.
interface alu_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [3*N_REQ-1:0] req_op;
  logic [W*N_REQ-1:0] req_a;
  logic [W*N_REQ-1:0] req_b;
  logic [2:0]         alu_op;
  logic [W-1:0]       alu_a;
  logic [W-1:0]       alu_b;
  logic [W-1:0]       alu_r;
  logic               alu_z;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [W-1:0]       rsp_r;
  logic               rsp_z;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_r, alu_z, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_r, rsp_z, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_r, alu_z, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_r, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU, one operation in flight.
// Optional busy-cycle counter output stat_busy when ALU_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | scan requesters from ptr, grant and latch the first valid one
// EXEC  | drive latched operands to the ALU; wait out cnt, then capture result
// RESP  | present tagged response until rsp_ready
module alu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0] stat_busy
`endif
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_found;
  logic [2:0]       sel_op;
  logic [W-1:0]     sel_a, sel_b;
  logic [2:0]       lat_op;
  logic [W-1:0]     lat_a, lat_b;
  logic [ID_W-1:0]  lat_id;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  rsp_id_q;
  logic [W-1:0]     rsp_r_q;
  logic             rsp_z_q;
  logic             rsp_err_q;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    int j;
    logic [ID_W-1:0] jj;
    gnt_found = 1'b0;
    gnt_id    = ptr;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j  = (int'(ptr) + i) % N_REQ;
      jj = ID_W'(j);
      if (!gnt_found && bus.req_valid[jj]) begin
        gnt_found = 1'b1;
        gnt_id    = jj;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_op = bus.req_op[3*i +: 3];
        sel_a  = bus.req_a[W*i +: W];
        sel_b  = bus.req_b[W*i +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_found)     state_nxt = EXEC;
      EXEC:    if (cnt == '0)     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Grant is suppressed while rst is high so reset cycles never show a req_ready pulse.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE:    if (gnt_found && !rst) bus.req_ready[gnt_id] = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      lat_op    <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_id    <= '0;
      cnt       <= '0;
      rsp_id_q  <= '0;
      rsp_r_q   <= '0;
      rsp_z_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            lat_op <= sel_op;
            lat_a  <= sel_a;
            lat_b  <= sel_b;
            lat_id <= gnt_id;
            cnt    <= (sel_op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_id_q  <= lat_id;
            rsp_r_q   <= bus.alu_r;
            rsp_z_q   <= bus.alu_z;
            rsp_err_q <= (lat_op == 3'b000) || (lat_op == 3'b111);
          end
        end
        RESP: begin
          if (bus.rsp_ready) ptr <= (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_op  = lat_op;
  assign bus.alu_a   = lat_a;
  assign bus.alu_b   = lat_b;
  assign bus.rsp_id  = rsp_id_q;
  assign bus.rsp_r   = rsp_r_q;
  assign bus.rsp_z   = rsp_z_q;
  assign bus.rsp_err = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stat_busy <= '0;
    else if (state != IDLE && stat_busy != 32'hFFFF_FFFF)
      stat_busy <= stat_busy + 32'd1;
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_alu_arbiter;
  localparam int N_REQ   = 4;
  localparam int W       = 32;
  localparam int MUL_LAT = 3;
  localparam int ID_W    = $clog2(N_REQ);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [W-1:0]    r;
    logic            z;
    logic            err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  rsp_t exp_q[$];
`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_busy;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  alu_arbiter #(.N_REQ(N_REQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_busy(stat_busy)
`endif
  );

  // Reference model of the shared combinational ALU.
  always_comb begin
    bus.alu_r = '0;
    case (bus.alu_op)
      3'b001:  bus.alu_r = bus.alu_a + bus.alu_b;
      3'b010:  bus.alu_r = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_r = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_r = bus.alu_a * bus.alu_b;
      3'b101:  bus.alu_r = bus.alu_a - bus.alu_b;
      3'b110:  bus.alu_r = {{(W-1){1'b0}}, (bus.alu_a < bus.alu_b)};
      default: bus.alu_r = '0;
    endcase
    bus.alu_z = (bus.alu_r == '0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input int id, input logic [W-1:0] r, input logic z, input logic err);
    rsp_t t;
    t.id  = ID_W'(id);
    t.r   = r;
    t.z   = z;
    t.err = err;
    return t;
  endfunction

  always @(negedge clk) begin : monitor
    rsp_t a, e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      a.id  = bus.rsp_id;
      a.r   = bus.rsp_r;
      a.z   = bus.rsp_z;
      a.err = bus.rsp_err;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d r=%0h, none expected", a.id, a.r);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", 64'(a), 64'(e));
      end
    end
  end

  task automatic set_payload(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[3*id +: 3] = op;
    bus.req_a[W*id +: W]  = a;
    bus.req_b[W*id +: W]  = b;
  endtask

  // Issue one request, wait for its grant, then check operand hold and response latency.
  task automatic request(input int id, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input rsp_t exp, input int exp_lat);
    int n;
    int lat;
    logic [ID_W-1:0] ix;
    ix = ID_W'(id);
    set_payload(id, op, a, b);
    bus.req_valid[ix] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[ix] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready[ix]) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout: id=%0d never granted, required grant", id);
      bus.req_valid[ix] = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1 bus.req_valid[ix] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 50) begin
      chk("alu_op_hold", 64'(bus.alu_op), 64'(op));
      chk("alu_a_hold", 64'(bus.alu_a), 64'(a));
      chk("alu_b_hold", 64'(bus.alu_b), 64'(b));
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency_id%0d_op%0d", id, op), 64'(lat), 64'(exp_lat));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(0));
    chk({tag, "_rsp_r"}, 64'(bus.rsp_r), 64'(0));
    chk({tag, "_rsp_z"}, 64'(bus.rsp_z), 64'(0));
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
    chk({tag, "_alu_op"}, 64'(bus.alu_op), 64'(0));
    chk({tag, "_alu_a"}, 64'(bus.alu_a), 64'(0));
    chk({tag, "_alu_b"}, 64'(bus.alu_b), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic ADD and MUL with latency and operand hold.
    request(0, 3'b001, 32'd5, 32'd7, mk(0, 32'd12, 1'b0, 1'b0), 2);
    request(2, 3'b100, 32'd6, 32'd7, mk(2, 32'd42, 1'b0, 1'b0), 1 + MUL_LAT);

    // Opcode coverage, zero flag, illegal ops, MUL truncation.
    request(3, 3'b101, 32'd3, 32'd3, mk(3, 32'd0, 1'b1, 1'b0), 2);
    request(1, 3'b110, 32'd2, 32'd9, mk(1, 32'd1, 1'b0, 1'b0), 2);
    request(0, 3'b111, 32'd8, 32'd8, mk(0, 32'd0, 1'b1, 1'b1), 2);
    request(2, 3'b000, 32'd4, 32'd4, mk(2, 32'd0, 1'b1, 1'b1), 2);
    request(0, 3'b010, 32'h0000_F0F0, 32'h0000_FF00, mk(0, 32'h0000_F000, 1'b0, 1'b0), 2);
    request(1, 3'b100, 32'h0001_0000, 32'h0001_0000, mk(1, 32'd0, 1'b1, 1'b0), 1 + MUL_LAT);
    request(3, 3'b100, 32'hFFFF_FFFF, 32'd2, mk(3, 32'hFFFF_FFFE, 1'b0, 1'b0), 1 + MUL_LAT);
    drain();

    // Round robin with every requester held valid after a reset.
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_payload(i, 3'b001, 32'(100 + i), 32'(i));
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(k % N_REQ, 32'(100 + 2 * (k % N_REQ)), 1'b0, 1'b0));
    bus.req_valid = '1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      @(negedge clk);
      while (bus.req_ready == '0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("rr_grant%0d", k), 64'(bus.req_ready), 64'(1) << (k % N_REQ));
      if (k > 0) chk($sformatf("rr_spacing%0d", k), 64'(cyc - last), 64'(3));
      last = cyc;
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    drain();

    // Response back-pressure with a competing requester waiting.
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    set_payload(3, 3'b001, 32'd20, 32'd22);
    bus.req_valid[3] = 1'b1;
    request(1, 3'b011, 32'h0000_00F0, 32'h0000_000F, mk(1, 32'h0000_00FF, 1'b0, 1'b0), 2);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("stall_rsp_hold", 64'({bus.rsp_id, bus.rsp_r, bus.rsp_z, bus.rsp_err}),
          64'(mk(1, 32'h0000_00FF, 1'b0, 1'b0)));
      chk("stall_req_ready", 64'(bus.req_ready), 64'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after_stall_grant", 64'(bus.req_ready), 64'(4'b1000));
    if (bus.req_ready[3]) exp_q.push_back(mk(3, 32'd42, 1'b0, 1'b0));
    @(posedge clk);
    #1 bus.req_valid[3] = 1'b0;
    drain();

    // Move ptr off zero, then reset in the middle of a MUL.
    @(posedge clk);
    #1;
    request(0, 3'b001, 32'd1, 32'd1, mk(0, 32'd2, 1'b0, 1'b0), 2);
    drain();
    @(posedge clk);
    #1;
    set_payload(2, 3'b100, 32'd6, 32'd7);
    bus.req_valid[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mul_grant", 64'(bus.req_ready), 64'(4'b0100));
    @(posedge clk);
    #1 bus.req_valid[2] = 1'b0;
    @(negedge clk);
    chk("mul_exec_a", 64'(bus.alu_a), 64'(6));
    @(posedge clk);
    #1 rst = 1'b1;
    set_payload(0, 3'b001, 32'd0, 32'd0);
    set_payload(3, 3'b001, 32'd20, 32'd22);
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    @(negedge clk);
    chk("rst_held_req_ready", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.req_ready), 64'(4'b0001));
    if (bus.req_ready[0]) exp_q.push_back(mk(0, 32'd0, 1'b1, 1'b0));
    @(posedge clk);
    #1 bus.req_valid = '0;
    drain();
    repeat (4) @(negedge clk);
    chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("idle_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
